port_write_demux: RTL and testbench
===================================

// Module: port_write_demux
// PURPOSE
//  CPU-side write path of the 8255-style parallel interface; the write-direction
//    counterpart of the 4-way read-out mux.
//  Captures bus writes (cs_n/wr_n/addr/din) and routes each one to one of four
//    registers: port A, port B, port C, control word.
//  Decodes control-word writes into mode-set or port-C bit set/reset (BSR).
//  Drives port output values and output enables to the pad logic.
// PARAMETERS
//  SYNC_STAGES  2      flops in each cs_n/wr_n synchronizer (>=2)
//  CW_RESET     8'h9B  control word after reset (mode 0, all ports input)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low
//  cs_n       in   1  chip select, active-low, asynchronous to clk
//  wr_n       in   1  write strobe, active-low, asynchronous; write commits on its rising edge
//  addr       in   2  register select: 0=A 1=B 2=C 3=control
//  din        in   8  write data
//  pa_out     out  8  port A output value
//  pb_out     out  8  port B output value
//  pc_out     out  8  port C output value
//  ctrl_word  out  8  last mode-set control word
//  pa_oe      out  1  port A drive enable   (= ~ctrl_word[4])
//  pb_oe      out  1  port B drive enable   (= ~ctrl_word[1])
//  pc_hi_oe   out  1  PC[7:4] drive enable  (= ~ctrl_word[3])
//  pc_lo_oe   out  1  PC[3:0] drive enable  (= ~ctrl_word[0])
//  wr_strobe  out  4  one-cycle pulse, bit n = register n updated
//  busy       out  1  high while FSM is not IDLE
// BEHAVIOUR
//  Reset (async, reset=0): pa/pb/pc_out=0, ctrl_word=CW_RESET, all oe=0,
//    wr_strobe=0, busy=0, FSM=IDLE, synchronizers preset to 1. Reset mid-write
//    discards the write.
//  cs_n/wr_n pass through SYNC_STAGES flops -> cs_s, wr_s. addr/din are not
//    synchronized: bus holds them stable >= SYNC_STAGES+1 clk before wr_n rises.
//  FSM:
//    IDLE    -> CAPTURE when cs_s=0 and wr_s=0.
//    CAPTURE -> each clk latch addr/din into hold regs.
//              cs_s=1 while wr_s=0 -> DRAIN (abort, no write).
//              wr_s=1 -> commit the hold regs -> IDLE.
//    DRAIN   -> IDLE once wr_s=1; no register changes.
//  Commit happens on the clk edge that leaves CAPTURE for IDLE. Registers and
//    wr_strobe[addr] update on that edge; strobe is high for exactly 1 cycle.
//    Latency from the wr_n pin rising edge to the update: SYNC_STAGES+1 edges.
//  Commit actions:
//    addr 0/1/2: the target port register takes din (wr_strobe bit 0/1/2).
//    addr 3, din[7]=1 (mode set): ctrl_word<=din; pa/pb/pc_out<=0; wr_strobe[3].
//    addr 3, din[7]=0 (BSR): pc_out[din[3:1]]<=din[0]; ctrl_word unchanged;
//      wr_strobe[2] pulses instead of [3].
//  Only mode 0 is implemented. ctrl_word[6:5] and ctrl_word[2] are stored but
//    have no effect.
//  Port registers are written regardless of their oe; the value is held for the
//    later switch to output.
//  Back-to-back writes: the next write is accepted only after IDLE has been
//    re-entered. wr_n low for fewer than SYNC_STAGES clk may be missed; bus
//    timing forbids it.
//  Simultaneous: cs_s and wr_s both rise on the same edge in CAPTURE -> commit
//    (wr_s=1 has priority over abort).
// STRUCTURE
//  Package port_if_pkg: ADDR_PA/PB/PC/CW localparams, FSM state encoding
//    (IDLE/CAPTURE/DRAIN), CW bit positions (CW_MODESET=7, CW_PA_IN=4,
//    CW_PCH_IN=3, CW_PB_IN=1, CW_PCL_IN=0).
//  Sub-module sync_bit (parameter STAGES, reset value 1): two instances, one for
//    cs_n and one for wr_n.
//  Everything else (FSM, hold regs, commit decode, oe assigns) lives in this module.
// TESTING (SYNC_STAGES=2)
//  Reset release -> pa/pb/pc_out=00, ctrl_word=9B, all oe=0, busy=0.
//  Write addr0 din=5A -> pa_out=5A exactly 3 clk edges after wr_n rises;
//    wr_strobe=0001 for 1 cycle.
//  Write addr3 din=80, after pa_out=5A -> ctrl_word=80, all oe=1, pa/pb/pc_out=00,
//    wr_strobe=1000.
//  BSR: addr3 din=0F -> pc_out=80. Then addr3 din=0E -> pc_out=00.
//    ctrl_word unchanged; wr_strobe=0100 each time.
//  Abort: cs_n rises 4 clk before wr_n rises during an addr1 write -> pb_out
//    unchanged, no strobe, busy falls after wr_n high.
//  reset asserted during CAPTURE of addr2 din=FF -> pc_out=00 immediately; no
//    strobe after release.

Source files
------------

// File: rtl/port_if_pkg.sv
// Shared encodings for the 8255-style write path: register addresses,
// control-word bit positions, FSM states and the captured write request.
package port_if_pkg;

  localparam logic [1:0] ADDR_PA = 2'd0;
  localparam logic [1:0] ADDR_PB = 2'd1;
  localparam logic [1:0] ADDR_PC = 2'd2;
  localparam logic [1:0] ADDR_CW = 2'd3;

  localparam int CW_MODESET = 7;
  localparam int CW_PA_IN   = 4;
  localparam int CW_PCH_IN  = 3;
  localparam int CW_PB_IN   = 1;
  localparam int CW_PCL_IN  = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_req_t;

endpackage

// File: rtl/port_write_demux_sync_bit.sv
// Multi-flop synchronizer for one asynchronous bus strobe; presets to 1
// so an idle (high) active-low strobe is seen during and after reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/port_write_demux.sv
// CPU write path of the parallel interface: synchronizes cs_n/wr_n, captures
// the bus write and commits it to port A/B/C or the control word on wr_n rise.
module port_write_demux
  import port_if_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CW_RESET    = 8'h9B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  output logic [7:0] ctrl_word,
  output logic       pa_oe,
  output logic       pb_oe,
  output logic       pc_hi_oe,
  output logic       pc_lo_oe,
  output logic [3:0] wr_strobe,
  output logic       busy
);

  logic cs_s, wr_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .reset(reset), .d(cs_n), .q(cs_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_wr (.clk(clk), .reset(reset), .d(wr_n), .q(wr_s));

  state_e     state_q, state_d;
  wr_req_t    hold_q, hold_d;
  logic [7:0] pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, cw_q, cw_d;
  logic [3:0] strobe_q, strobe_d;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    pc_d     = pc_q;
    cw_d     = cw_q;
    strobe_d = '0;
    case (state_q)
      IDLE: begin
        if (!cs_s && !wr_s) begin
          state_d = CAPTURE;
          hold_d  = '{addr: addr, data: din};
        end
      end
      CAPTURE: begin
        hold_d = '{addr: addr, data: din};
        // A rising wr_s wins over a simultaneous cs_s rise: the write commits.
        if (wr_s) begin
          state_d = IDLE;
          case (hold_q.addr)
            ADDR_PA: begin pa_d = hold_q.data; strobe_d[0] = 1'b1; end
            ADDR_PB: begin pb_d = hold_q.data; strobe_d[1] = 1'b1; end
            ADDR_PC: begin pc_d = hold_q.data; strobe_d[2] = 1'b1; end
            ADDR_CW: begin
              if (hold_q.data[CW_MODESET]) begin
                cw_d        = hold_q.data;
                pa_d        = '0;
                pb_d        = '0;
                pc_d        = '0;
                strobe_d[3] = 1'b1;
              end else begin
                // Bit set/reset only touches one port C bit.
                pc_d[hold_q.data[3:1]] = hold_q.data[0];
                strobe_d[2]            = 1'b1;
              end
            end
          endcase
        end else if (cs_s) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      pc_q     <= '0;
      cw_q     <= CW_RESET;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      pc_q     <= pc_d;
      cw_q     <= cw_d;
      strobe_q <= strobe_d;
    end
  end

  assign pa_out    = pa_q;
  assign pb_out    = pb_q;
  assign pc_out    = pc_q;
  assign ctrl_word = cw_q;
  assign pa_oe     = ~cw_q[CW_PA_IN];
  assign pb_oe     = ~cw_q[CW_PB_IN];
  assign pc_hi_oe  = ~cw_q[CW_PCH_IN];
  assign pc_lo_oe  = ~cw_q[CW_PCL_IN];
  assign wr_strobe = strobe_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_port_write_demux.sv
// Directed bench for port_write_demux with SYNC_STAGES=2: reset state, commit
// latency, mode set, BSR, abort, reset during capture and simultaneous release.
module tb_port_write_demux;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n, wr_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] pa_out, pb_out, pc_out, ctrl_word;
  logic       pa_oe, pb_oe, pc_hi_oe, pc_lo_oe, busy;
  logic [3:0] wr_strobe;

  int errors = 0;
  int checks = 0;

  port_write_demux #(.SYNC_STAGES(2), .CW_RESET(8'h9B)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
    .pa_out(pa_out), .pb_out(pb_out), .pc_out(pc_out), .ctrl_word(ctrl_word),
    .pa_oe(pa_oe), .pb_oe(pb_oe), .pc_hi_oe(pc_hi_oe), .pc_lo_oe(pc_lo_oe),
    .wr_strobe(wr_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive cs_n/wr_n low with stable addr/din long enough to reach CAPTURE.
  task automatic wr_begin(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raise wr_n and return just after the third rising edge (the commit edge).
  task automatic wr_rise();
    wr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Confirm the strobe lasts one cycle, then drop chip select.
  task automatic wr_end(input string tag);
    @(posedge clk); #1;
    chk({tag, " strobe clears"}, {28'd0, wr_strobe}, 32'h0);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic [3:0] seen;

  initial begin
    reset = 1'b0; cs_n = 1'b1; wr_n = 1'b1; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst pa", {24'd0, pa_out}, 32'h00);
    chk("rst pb", {24'd0, pb_out}, 32'h00);
    chk("rst pc", {24'd0, pc_out}, 32'h00);
    chk("rst cw", {24'd0, ctrl_word}, 32'h9B);
    chk("rst oe", {28'd0, pa_oe, pb_oe, pc_hi_oe, pc_lo_oe}, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'h0);
    chk("rst strobe", {28'd0, wr_strobe}, 32'h0);

    // Port A write with edge-by-edge latency check.
    wr_begin(2'd0, 8'h5A);
    chk("pa busy", {31'd0, busy}, 32'h1);
    wr_n = 1'b1;
    @(posedge clk); #1;
    chk("pa edge1", {24'd0, pa_out}, 32'h00);
    @(posedge clk); #1;
    chk("pa edge2", {24'd0, pa_out}, 32'h00);
    chk("pa edge2 strobe", {28'd0, wr_strobe}, 32'h0);
    @(posedge clk); #1;
    chk("pa edge3", {24'd0, pa_out}, 32'h5A);
    chk("pa strobe", {28'd0, wr_strobe}, 32'h1);
    chk("pa idle", {31'd0, busy}, 32'h0);
    wr_end("pa");

    // Ports B and C are written even though they are inputs.
    wr_begin(2'd1, 8'hC3); wr_rise();
    chk("pb val", {24'd0, pb_out}, 32'hC3);
    chk("pb strobe", {28'd0, wr_strobe}, 32'h2);
    wr_end("pb");
    wr_begin(2'd2, 8'h3C); wr_rise();
    chk("pc val", {24'd0, pc_out}, 32'h3C);
    chk("pc strobe", {28'd0, wr_strobe}, 32'h4);
    wr_end("pc");

    // Mode set: all outputs, ports cleared.
    wr_begin(2'd3, 8'h80); wr_rise();
    chk("ms cw", {24'd0, ctrl_word}, 32'h80);
    chk("ms oe", {28'd0, pa_oe, pb_oe, pc_hi_oe, pc_lo_oe}, 32'hF);
    chk("ms ports", {8'd0, pa_out, pb_out, pc_out}, 32'h0);
    chk("ms strobe", {28'd0, wr_strobe}, 32'h8);
    wr_end("ms");

    // BSR set bit 7, clear bit 7, set bit 0.
    wr_begin(2'd3, 8'h0F); wr_rise();
    chk("bsr set7 pc", {24'd0, pc_out}, 32'h80);
    chk("bsr set7 cw", {24'd0, ctrl_word}, 32'h80);
    chk("bsr set7 strobe", {28'd0, wr_strobe}, 32'h4);
    wr_end("bsr set7");
    wr_begin(2'd3, 8'h0E); wr_rise();
    chk("bsr clr7 pc", {24'd0, pc_out}, 32'h00);
    chk("bsr clr7 cw", {24'd0, ctrl_word}, 32'h80);
    chk("bsr clr7 strobe", {28'd0, wr_strobe}, 32'h4);
    wr_end("bsr clr7");
    wr_begin(2'd3, 8'h01); wr_rise();
    chk("bsr set0 pc", {24'd0, pc_out}, 32'h01);
    wr_end("bsr set0");

    // Abort: cs_n rises 4 clk before wr_n on a port B write.
    wr_begin(2'd1, 8'h11); wr_rise(); wr_end("pb pre");
    chk("abort pre pb", {24'd0, pb_out}, 32'h11);
    seen = '0;
    wr_begin(2'd1, 8'h77);
    cs_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; seen |= wr_strobe; end
    chk("abort drain busy", {31'd0, busy}, 32'h1);
    @(negedge clk);
    wr_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; seen |= wr_strobe; end
    chk("abort pb", {24'd0, pb_out}, 32'h11);
    chk("abort no strobe", {28'd0, seen}, 32'h0);
    chk("abort busy", {31'd0, busy}, 32'h0);

    // Reset in the middle of a capture discards the write.
    wr_begin(2'd2, 8'hA5); wr_rise(); wr_end("pc pre");
    chk("rc pre pc", {24'd0, pc_out}, 32'hA5);
    wr_begin(2'd2, 8'hFF);
    chk("rc capture busy", {31'd0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rc pc async", {24'd0, pc_out}, 32'h00);
    chk("rc cw async", {24'd0, ctrl_word}, 32'h9B);
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = '0;
    repeat (6) begin @(posedge clk); #1; seen |= wr_strobe; end
    chk("rc no strobe", {28'd0, seen}, 32'h0);
    chk("rc pc after", {24'd0, pc_out}, 32'h00);
    chk("rc busy", {31'd0, busy}, 32'h0);

    // cs_n and wr_n rise together: still commits.
    wr_begin(2'd0, 8'h96);
    cs_n = 1'b1;
    wr_rise();
    chk("sim pa", {24'd0, pa_out}, 32'h96);
    chk("sim strobe", {28'd0, wr_strobe}, 32'h1);
    wr_end("sim");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
